// File: rtl/pcie_dl_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_dl_tx_scheduler
//  Description : Packet-granular fixed-priority arbiter onto the PHY transmit
//                stream with a starvation guard for the TLP source.
//                Optional per-source packet statistics: PCIE_TX_SCHED_STATS_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module pcie_dl_tx_scheduler #(
  parameter int DATA_WIDTH   = 32,
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int USER_WIDTH   = 3,
  parameter int S_COUNT      = 3,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            phy_link_up_i,
  input  logic [S_COUNT*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [S_COUNT-1:0]              s_axis_tvalid,
  input  logic [S_COUNT-1:0]              s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0]   s_axis_tuser,
  output logic [S_COUNT-1:0]              s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  output logic [USER_WIDTH-1:0]           m_axis_tuser,
  input  logic                            m_axis_tready,
  output logic [$clog2(S_COUNT)-1:0]      grant_o,
  output logic                            busy_o,
  output logic [S_COUNT*CNT_WIDTH-1:0]    pkt_cnt_o
);

  localparam int c_grant_w  = $clog2(S_COUNT);
  localparam int c_starve_w = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_grant_w-1:0]  c_tlp_src    = c_grant_w'(S_COUNT - 1);
  localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t                  r_state;
  logic [c_grant_w-1:0]    r_grant;
  logic [c_starve_w-1:0]   r_starve_cnt;
  logic                    r_busy;

  logic [c_grant_w-1:0]    w_winner;
  logic                    w_tlp_valid;
  logic                    w_any_valid;
  logic                    w_xfer;
  logic                    w_pkt_done;
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic [KEEP_WIDTH-1:0]   w_sel_keep;
  logic [USER_WIDTH-1:0]   w_sel_user;
  logic                    w_sel_valid;
  logic                    w_sel_last;

  assign w_tlp_valid = s_axis_tvalid[S_COUNT-1];
  assign w_any_valid = |s_axis_tvalid;
  assign w_xfer      = (r_state == ST_XFER);

  // Lowest requesting index wins unless the TLP source has been passed over too often.
  always_comb begin
    w_winner = c_tlp_src;
    for (int i = S_COUNT - 1; i >= 0; i--) begin
      if (s_axis_tvalid[i]) begin
        w_winner = c_grant_w'(i);
      end
    end
    if (w_tlp_valid && (r_starve_cnt >= c_starve_max)) begin
      w_winner = c_tlp_src;
    end
  end

  always_comb begin
    w_sel_data    = '0;
    w_sel_keep    = '0;
    w_sel_user    = '0;
    w_sel_valid   = 1'b0;
    w_sel_last    = 1'b0;
    s_axis_tready = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (r_grant == c_grant_w'(i)) begin
        w_sel_data       = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_keep       = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        w_sel_user       = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        w_sel_valid      = s_axis_tvalid[i];
        w_sel_last       = s_axis_tlast[i];
        s_axis_tready[i] = w_xfer & m_axis_tready;
      end
    end
  end

  assign m_axis_tdata  = w_xfer ? w_sel_data  : '0;
  assign m_axis_tkeep  = w_xfer ? w_sel_keep  : '0;
  assign m_axis_tuser  = w_xfer ? w_sel_user  : '0;
  assign m_axis_tvalid = w_xfer & w_sel_valid;
  assign m_axis_tlast  = w_xfer & w_sel_last;

  assign w_pkt_done = w_xfer & w_sel_valid & m_axis_tready & w_sel_last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_starve_cnt <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (phy_link_up_i && w_any_valid) begin
            r_state <= ST_XFER;
            r_busy  <= 1'b1;
            r_grant <= w_winner;
            if (w_tlp_valid && (w_winner != c_tlp_src)) begin
              r_starve_cnt <= (r_starve_cnt >= c_starve_max) ? c_starve_max
                                                              : r_starve_cnt + 1'b1;
            end else begin
              r_starve_cnt <= '0;
            end
          end
        end
        ST_XFER: begin
          // Grant is held through source bubbles until the last beat is taken.
          if (w_pkt_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_o = r_grant;
  assign busy_o  = r_busy;

`ifdef PCIE_TX_SCHED_STATS_EN
  logic [S_COUNT*CNT_WIDTH-1:0] r_pkt_cnt;

  for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_stats
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_pkt_cnt[gi*CNT_WIDTH +: CNT_WIDTH] <= '0;
      end else if (w_pkt_done && (r_grant == c_grant_w'(gi))) begin
        r_pkt_cnt[gi*CNT_WIDTH +: CNT_WIDTH] <= r_pkt_cnt[gi*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
      end
    end
  end

  assign pkt_cnt_o = r_pkt_cnt;
`else
  assign pkt_cnt_o = '0;
`endif

endmodule
`default_nettype wire
